monolith_host_ctrl: RTL and testbench
=====================================

Name: monolith_host_ctrl

Overview:
Initiator-side sequencer for the Monolith-31 hash engine's level-held go/valid interface. Accepts hash/compress jobs on a valid/ready request channel and canonicalises operands mod p = 2^31-1. Drives go/in1/in2/hash_or_compress for the job's full duration, captures out on valid, then drops go to re-arm the engine. Returns the result on a valid/ready response channel with tag passthrough and a timeout error.

Parameters:
TAG_W, 4, width of request/response tag
TIMEOUT, 1023, max cycles go is held waiting for eng_valid before error
GO_LOW_CYCLES, 1, minimum cycles eng_go is held low between jobs (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request offered
req_ready  out  1  request accepted when req_valid & req_ready
req_mode  in  1  0 = hash, 1 = compress
req_in1  in  31  first operand
req_in2  in  31  second operand, ignored when req_mode=0
req_tag  in  TAG_W  opaque job tag
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_out  out  31  hash result
rsp_tag  out  TAG_W  tag of the completed job
rsp_err  out  1  1 = timeout; rsp_out = 0
eng_go  out  1  engine go, held high for the whole job
eng_in1  out  31  engine operand 1
eng_in2  out  31  engine operand 2, driven 0 in hash mode
eng_hash_or_compress  out  1  engine mode
eng_out  in  31  engine result
eng_valid  in  1  engine result valid, stable while go high
busy  out  1  state != IDLE or rsp_valid

Behaviour:
- Reset: state=IDLE; eng_go=0; eng_in1/eng_in2/eng_hash_or_compress=0; rsp_valid=0; rsp_out/rsp_tag/rsp_err=0; timeout counter=0; recover counter=0.
- Reset mid-job: eng_go drops next edge (hard-resets the engine); any pending response is discarded.
- All outputs are registered. req_ready = (state==IDLE).
- Canonicalisation on accept: an operand equal to 31'h7FFF_FFFF becomes 0. In hash mode, in2 is latched as 0.
- IDLE: on handshake, latch the operands, mode and tag; next edge set eng_go=1 and go to RUN; clear the timeout counter.
- RUN: eng_go, eng_in1, eng_in2 and mode stay constant. The timeout counter increments each cycle.
  - If eng_valid=1 and the response register is free (rsp_valid=0, or rsp_ready=1 this cycle): capture eng_out, tag and err=0 into the response; next edge rsp_valid=1, eng_go=0, go to RECOVER.
  - If eng_valid=1 but the response register is occupied: stay in RUN with go held. The engine's out remains stable, so the capture is simply deferred. The timeout does not advance while eng_valid=1.
  - If the counter reaches TIMEOUT with eng_valid=0 and the response register is free: respond with err=1, rsp_out=0; drop go; go to RECOVER. If the register is occupied, hold at TIMEOUT until it frees.
- RECOVER: eng_go=0 for GO_LOW_CYCLES cycles, then return to IDLE. Requests are refused during RECOVER.
- Response register: single entry. rsp_valid is cleared on handshake. Simultaneous handshake and new capture → the new result is loaded and rsp_valid stays 1.
- Latency (engine latency L, response register free): accept at cycle 0; eng_go=1 at cycle 1; eng_valid seen at cycle 1+L; rsp_valid=1 at cycle 2+L.
- Back-to-back throughput: one job per L+2+GO_LOW_CYCLES cycles.

Decomposition:
- monolith_pkg: M31_P = 31'h7FFF_FFFF; mode enum {MODE_HASH=0, MODE_COMPRESS=1}; ctrl state enum {IDLE, RUN, RECOVER}; function m31_canon(x).
- Sub-module monolith_rsp_reg: single-entry valid/ready output register holding out/tag/err, with a load-while-draining path.
- Top keeps the FSM and counters.

Test Plan:
- The bench uses a behavioural engine stub: latency 10 cycles after go rises; out = (in1+in2) mod p; valid held while go=1.
- Hash: req in1=5, in2=9, mode=0, tag=3, rsp_ready=1 → eng_in2=0; rsp_out=5, tag=3, err=0; rsp_valid exactly 12 cycles after accept; eng_go low ≥1 cycle afterwards.
- Compress with canonicalisation: in1=0x7FFFFFFF, in2=7 → eng_in1=0; rsp_out=7.
- Backpressure: rsp_ready=0; issue job A (tag 1), then job B (tag 2) → B stays in RUN with eng_go held past eng_valid; raise rsp_ready → A returned, then B; no result lost or duplicated.
- Timeout: TIMEOUT=20, stub never asserts valid → rsp_err=1, rsp_out=0 at cycle 22; eng_go drops; next job completes normally.
- Reset mid-RUN at cycle 5 → eng_go=0, rsp_valid=0 next edge; req_ready=1 in IDLE; the following job's result is correct.

Source files
------------

// File: rtl/monolith_pkg.sv
// monolith_pkg: shared types, constants and helpers for the Monolith-31 host controller
package monolith_pkg;
  localparam logic [30:0] M31_P = 31'h7FFF_FFFF;
  typedef enum logic {MODE_HASH = 1'b0, MODE_COMPRESS = 1'b1} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, RECOVER} ctrl_state_e;
  // p itself is congruent to 0, every other 31-bit value is already canonical
  function automatic logic [30:0] m31_canon(input logic [30:0] x);
    return (x == M31_P) ? '0 : x;
  endfunction
endpackage

// File: rtl/monolith_rsp_reg.sv
// monolith_rsp_reg: single-entry valid/ready response register with load-while-draining
module monolith_rsp_reg #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [30:0]      out_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             err_i,
  input  logic             rsp_ready_i,
  output logic             free_o,
  output logic             rsp_valid_o,
  output logic [30:0]      rsp_out_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o
);
  logic             valid_q;
  logic [30:0]      out_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  assign free_o      = !valid_q || rsp_ready_i;
  assign rsp_valid_o = valid_q;
  assign rsp_out_o   = out_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_err_o   = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      out_q   <= out_i;
      tag_q   <= tag_i;
      err_q   <= err_i;
    end else if (rsp_ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/monolith_host_ctrl.sv
// monolith_host_ctrl: sequences hash/compress jobs onto the level-held go/valid Monolith-31 engine
module monolith_host_ctrl
  import monolith_pkg::*;
#(
  parameter int TAG_W         = 4,
  parameter int TIMEOUT       = 1023,
  parameter int GO_LOW_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_mode_i,
  input  logic [30:0]      req_in1_i,
  input  logic [30:0]      req_in2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [30:0]      rsp_out_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             eng_go_o,
  output logic [30:0]      eng_in1_o,
  output logic [30:0]      eng_in2_o,
  output logic             eng_hash_or_compress_o,
  input  logic [30:0]      eng_out_i,
  input  logic             eng_valid_i,
  output logic             busy_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(GO_LOW_CYCLES + 1);
  ctrl_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rec_q, rec_d;
  logic [30:0]      in1_q, in1_d, in2_q, in2_d;
  mode_e            mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             accept, timed_out, load, free;
  assign accept    = req_valid_i && state_q == IDLE;
  assign timed_out = cnt_q == CW'(TIMEOUT);
  // a held engine result wins over an expiring timeout
  assign load      = state_q == RUN && free && (eng_valid_i || timed_out);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      in1_d   = m31_canon(req_in1_i);
      in2_d   = req_mode_i ? m31_canon(req_in2_i) : '0;
      mode_d  = mode_e'(req_mode_i);
      tag_d   = req_tag_i;
    end
    if (state_q == RUN) begin
      if (load) begin
        state_d = RECOVER;
        rec_d   = '0;
      end else if (!eng_valid_i && !timed_out) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (state_q == RECOVER) begin
      rec_d   = rec_q + 1'b1;
      state_d = (rec_q == RW'(GO_LOW_CYCLES - 1)) ? IDLE : RECOVER;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rec_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      mode_q  <= MODE_HASH;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end
  monolith_rsp_reg #(.TAG_W(TAG_W)) u_rsp (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .out_i       (eng_valid_i ? eng_out_i : 31'd0),
    .tag_i       (tag_q),
    .err_i       (!eng_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .free_o      (free),
    .rsp_valid_o (rsp_valid_o),
    .rsp_out_o   (rsp_out_o),
    .rsp_tag_o   (rsp_tag_o),
    .rsp_err_o   (rsp_err_o)
  );
  assign req_ready_o            = state_q == IDLE;
  assign eng_go_o               = state_q == RUN;
  assign eng_in1_o              = in1_q;
  assign eng_in2_o              = in2_q;
  assign eng_hash_or_compress_o = mode_q;
  assign busy_o                 = state_q != IDLE || rsp_valid_o;
endmodule

// File: tb/tb_monolith_host_ctrl.sv
// tb_monolith_host_ctrl: table, hand-sequence and randomized checks with an engine stub and reference model
module tb_monolith_host_ctrl;
  localparam longint unsigned P = 64'h7FFF_FFFF;
  localparam int LAT = 10;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, req_mode = 0;
  logic [30:0] req_in1 = 0, req_in2 = 0;
  logic [3:0]  req_tag = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_err;
  logic [30:0] rsp_out;
  logic [3:0]  rsp_tag;
  logic        eng_go, eng_hash_or_compress, eng_valid, busy;
  logic [30:0] eng_in1, eng_in2, eng_out;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  monolith_host_ctrl #(.TAG_W(4), .TIMEOUT(20), .GO_LOW_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mode_i(req_mode),
    .req_in1_i(req_in1), .req_in2_i(req_in2), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_out_o(rsp_out),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
    .eng_go_o(eng_go), .eng_in1_o(eng_in1), .eng_in2_o(eng_in2),
    .eng_hash_or_compress_o(eng_hash_or_compress),
    .eng_out_i(eng_out), .eng_valid_i(eng_valid), .busy_o(busy)
  );
  // engine stub: result valid LAT cycles after go rises, held while go stays high
  bit stub_en = 1;
  int unsigned stub_cnt = 0;
  always @(posedge clk) stub_cnt <= eng_go ? stub_cnt + 1 : 0;
  assign eng_valid = stub_en && eng_go && stub_cnt >= LAT;
  assign eng_out   = 31'((longint'(eng_in1) + longint'(eng_in2)) % P);
  function automatic logic [30:0] ref_result(input logic m, input logic [30:0] a, input logic [30:0] b);
    longint unsigned x, y;
    x = (a == 31'h7FFF_FFFF) ? 0 : longint'(a);
    y = !m ? 0 : (b == 31'h7FFF_FFFF) ? 0 : longint'(b);
    return 31'((x + y) % P);
  endfunction
  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic m, input logic [30:0] a, input logic [30:0] b, input logic [3:0] t);
    int n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1; req_mode = m; req_in1 = a; req_in2 = b; req_tag = t;
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
  endtask
  typedef struct { logic [30:0] out; logic [3:0] tag; } exp_t;
  exp_t q[$];
  exp_t e;
  bit mon_en = 0;
  always @(negedge clk) if (mon_en) begin
    if (req_valid && req_ready) q.push_back('{ref_result(req_mode, req_in1, req_in2), req_tag});
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rnd_unexpected_rsp", 1, 0);
      else begin
        e = q.pop_front();
        chk("rnd_out", rsp_out, e.out);
        chk("rnd_tag", rsp_tag, e.tag);
        chk("rnd_err", rsp_err, 0);
      end
    end
  end
  typedef struct { logic mode; logic [30:0] in1, in2; logic [3:0] tag; logic [30:0] out, ein1, ein2; } vec_t;
  vec_t vt[6];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit rnd_done;
    vt[0] = '{1'b0, 31'd5,          31'd9,          4'd3,  31'd5, 31'd5,          31'd0};
    vt[1] = '{1'b1, 31'h7FFF_FFFF,  31'd7,          4'd4,  31'd7, 31'd0,          31'd7};
    vt[2] = '{1'b1, 31'h7FFF_FFFE,  31'd5,          4'd5,  31'd4, 31'h7FFF_FFFE,  31'd5};
    vt[3] = '{1'b1, 31'h7FFF_FFFF,  31'h7FFF_FFFF,  4'hF,  31'd0, 31'd0,          31'd0};
    vt[4] = '{1'b0, 31'h7FFF_FFFF,  31'd123,        4'd0,  31'd0, 31'd0,          31'd0};
    vt[5] = '{1'b1, 31'h4000_0000,  31'h3FFF_FFFF,  4'd9,  31'd0, 31'h4000_0000,  31'h3FFF_FFFF};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_eng_go", eng_go, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_in1", eng_in1, 0);
    chk("rst_eng_in2", eng_in2, 0);
    chk("rst_mode", eng_hash_or_compress, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].mode, vt[i].in1, vt[i].in2, vt[i].tag);
      chk("vec_go", eng_go, 1);
      chk("vec_eng_in1", eng_in1, vt[i].ein1);
      chk("vec_eng_in2", eng_in2, vt[i].ein2);
      chk("vec_eng_mode", eng_hash_or_compress, vt[i].mode);
      chk("vec_busy", busy, 1);
      wait_rsp(n);
      chk("vec_latency", n, 12);
      chk("vec_out", rsp_out, vt[i].out);
      chk("vec_tag", rsp_tag, vt[i].tag);
      chk("vec_err", rsp_err, 0);
      chk("vec_go_low", eng_go, 0);
      chk("vec_refused_in_recover", req_ready, 0);
      @(posedge clk); #1;
      chk("vec_drained", rsp_valid, 0);
      chk("vec_go_still_low", eng_go, 0);
      chk("vec_ready_again", req_ready, 1);
    end
    rsp_ready = 0;
    issue(1'b1, 31'd100, 31'd200, 4'd1);
    wait_rsp(n);
    chk("bp_a_valid", rsp_valid, 1);
    chk("bp_a_tag", rsp_tag, 1);
    issue(1'b1, 31'd300, 31'd400, 4'd2);
    repeat (15) begin @(posedge clk); #1; end
    chk("bp_go_held", eng_go, 1);
    chk("bp_eng_valid", eng_valid, 1);
    chk("bp_hold_tag", rsp_tag, 1);
    chk("bp_hold_out", rsp_out, 300);
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_b_valid", rsp_valid, 1);
    chk("bp_b_tag", rsp_tag, 2);
    chk("bp_b_out", rsp_out, 700);
    chk("bp_b_go_low", eng_go, 0);
    @(posedge clk); #1;
    chk("bp_b_drained", rsp_valid, 0);
    stub_en = 0;
    issue(1'b0, 31'd11, 31'd22, 4'd6);
    wait_rsp(n);
    chk("to_latency", n, 22);
    chk("to_err", rsp_err, 1);
    chk("to_out", rsp_out, 0);
    chk("to_tag", rsp_tag, 6);
    chk("to_go_low", eng_go, 0);
    stub_en = 1;
    @(posedge clk); #1;
    issue(1'b1, 31'd1, 31'd2, 4'd7);
    wait_rsp(n);
    chk("post_to_latency", n, 12);
    chk("post_to_out", rsp_out, 3);
    chk("post_to_err", rsp_err, 0);
    @(posedge clk); #1;
    rsp_ready = 0;
    issue(1'b0, 31'd50, 31'd0, 4'd9);
    wait_rsp(n);
    issue(1'b0, 31'd40, 31'd0, 4'd8);
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mid_go_before", eng_go, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("rst_mid_go", eng_go, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);
    reset = 0;
    rsp_ready = 1;
    issue(1'b1, 31'd5, 31'd6, 4'd10);
    wait_rsp(n);
    chk("rst_post_latency", n, 12);
    chk("rst_post_out", rsp_out, 11);
    chk("rst_post_tag", rsp_tag, 10);
    @(posedge clk); #1;
    mon_en = 1;
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          issue(1'($urandom),
                ($urandom % 6 == 0) ? 31'h7FFF_FFFF : 31'($urandom),
                ($urandom % 6 == 0) ? 31'h7FFF_FFFF : 31'($urandom),
                4'($urandom));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin @(posedge clk); #1; rsp_ready = ($urandom % 4) != 0; end
      end
    join
    rsp_ready = 1;
    n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin @(posedge clk); #1; n++; end
    chk("rnd_drain", q.size(), 0);
    chk("rnd_idle", busy, 0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
